mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_rr_arbiter.sv | 30 +++
 rtl/mem_access_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StComplete
  } state_e;

  typedef enum logic [1:0] {
    DtByte = 2'b00,
    DtHalf = 2'b01,
    DtWord = 2'b10,
    DtRsvd = 2'b11
  } dt_e;

  localparam int unsigned TimeoutDefault = 15;

  // Reserved size or an address not aligned to the access size.
  function automatic logic access_bad(input logic [1:0] dt, input logic [7:0] addr);
    return (dt == DtRsvd) || (dt == DtHalf && addr[0]) ||
           (dt == DtWord && addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Fetch port, data port and RAM handshake of the memory access controller.
interface mem_access_ctrl_if;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ack;
  logic        f_err;
  logic [31:0] f_rdata;

  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_dt;
  logic        d_sign;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;

  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic        mem_mov;
  logic [1:0]  mem_dt;
  logic        mem_sign;
  logic [31:0] mem_rdata;
  logic        mem_moc;

  logic        busy;

  modport slave (
    input  f_req, f_addr, d_req, d_rw, d_dt, d_sign, d_addr, d_wdata, mem_rdata, mem_moc,
    output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
    output mem_addr, mem_wdata, mem_rw, mem_mov, mem_dt, mem_sign, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_rw, d_dt, d_sign, d_addr, d_wdata, mem_rdata, mem_moc,
    input  f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
    input  mem_addr, mem_wdata, mem_rw, mem_mov, mem_dt, mem_sign, busy
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter; bit 0 is fetch, bit 1 is data.
module mem_rr_arbiter (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // Set when data was granted last; reset value makes fetch win the first tie.
  logic last_data_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_data_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_data_q <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_data_q <= gnt[1];
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch and data requests onto one RAM handshake
// with alignment checking and an access timeout. All outputs are registered.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic              clk,
  input logic              clr,
  mem_access_ctrl_if.slave bus
);
  localparam logic [3:0] CntLast = 4'(TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       gnt_data_q;
  logic [1:0] gnt;
  logic [7:0] req_addr;
  logic [1:0] req_dt;
  logic       done_err;

  mem_rr_arbiter u_arb (
    .clk (clk),
    .clr (clr),
    .en  (state_q == StIdle),
    .req ({bus.d_req, bus.f_req}),
    .gnt (gnt)
  );

  assign req_addr = gnt[1] ? bus.d_addr : bus.f_addr;
  assign req_dt   = gnt[1] ? bus.d_dt : DtWord;
  assign done_err = !bus.mem_moc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      gnt_data_q    <= 1'b0;
      bus.f_ack     <= 1'b0;
      bus.f_err     <= 1'b0;
      bus.f_rdata   <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rw    <= 1'b0;
      bus.mem_mov   <= 1'b0;
      bus.mem_dt    <= '0;
      bus.mem_sign  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.f_ack <= 1'b0;
      bus.f_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt != 2'b00) begin
            gnt_data_q    <= gnt[1];
            bus.mem_addr  <= req_addr;
            bus.mem_dt    <= req_dt;
            bus.mem_rw    <= gnt[1] ? bus.d_rw : 1'b1;
            bus.mem_sign  <= gnt[1] & bus.d_sign;
            bus.mem_wdata <= gnt[1] ? bus.d_wdata : '0;
            bus.busy      <= 1'b1;
            // Bad accesses never reach the RAM; they complete with an error straight away.
            if (access_bad(req_dt, req_addr)) begin
              state_q   <= StComplete;
              bus.f_ack <= gnt[0];
              bus.f_err <= gnt[0];
              bus.d_ack <= gnt[1];
              bus.d_err <= gnt[1];
            end else begin
              state_q <= StSetup;
            end
          end
        end
        StSetup: begin
          state_q     <= StAccess;
          bus.mem_mov <= 1'b1;
          cnt_q       <= '0;
        end
        StAccess: begin
          // mem_moc takes priority over a timeout landing on the same edge.
          if (bus.mem_moc || cnt_q == CntLast) begin
            state_q     <= StComplete;
            bus.mem_mov <= 1'b0;
            bus.f_ack   <= !gnt_data_q;
            bus.f_err   <= !gnt_data_q && done_err;
            bus.d_ack   <= gnt_data_q;
            bus.d_err   <= gnt_data_q && done_err;
            if (bus.mem_moc && bus.mem_rw) begin
              if (gnt_data_q) begin
                bus.d_rdata <= bus.mem_rdata;
              end else begin
                bus.f_rdata <= bus.mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StComplete: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
